ps2_key_decoder: RTL and testbench

//  PS/2 keyboard receiver and scan-code decoder for the calculator keypad path.
//  - Oversamples ps2_clk/ps2_data and deglitches ps2_clk.
//  - Receives 11-bit frames with parity/stop checking and a frame timeout.
//  - Decodes E0/F0 prefixes; reports make and break events with an ASCII map.
//  - Events are buffered in a FIFO behind a valid/ready handshake to the calculator core.

---
 rtl/ps2_pkg.sv | 35 +++
 rtl/ps2_key_decoder_if.sv | 19 +
 rtl/ps2_frame_rx.sv | 110 +++++++++++
 rtl/ps2_key_decoder.sv | 99 +++++++++
 tb/tb_ps2_key_decoder.sv | 310 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ps2_pkg.sv
// Shared constants, frame FSM encoding and scan-code to ASCII map for the PS/2 keypad path.
package ps2_pkg;

  localparam logic [7:0] PS2_PREFIX_EXT = 8'hE0;
  localparam logic [7:0] PS2_PREFIX_BRK = 8'hF0;
  localparam logic [7:0] ASCII_INVALID  = 8'hFE;

  typedef enum logic [1:0] {StIdle, StData, StParity, StStop} rx_state_e;

  // Only keypad enter is meaningful among extended codes.
  function automatic logic [7:0] ps2_to_ascii(input logic ext, input logic [7:0] code);
    logic [7:0] a;
    a = ASCII_INVALID;
    if (ext) begin
      if (code == 8'h5A) a = 8'h0A;
    end else begin
      case (code)
        8'h16:   a = 8'h31;
        8'h1E:   a = 8'h32;
        8'h26:   a = 8'h33;
        8'h25:   a = 8'h34;
        8'h2E:   a = 8'h35;
        8'h36:   a = 8'h36;
        8'h3D:   a = 8'h37;
        8'h3E:   a = 8'h38;
        8'h46:   a = 8'h39;
        8'h45:   a = 8'h30;
        8'h5A:   a = 8'h0A;
        default: a = ASCII_INVALID;
      endcase
    end
    return a;
  endfunction

endpackage

// File: rtl/ps2_key_decoder_if.sv
// Key event valid/ready stream between the PS/2 decoder and the calculator core.
interface ps2_key_decoder_if;
  logic       key_valid;
  logic       key_ready;
  logic [7:0] key_code;
  logic       key_break;
  logic       key_ext;
  logic [7:0] key_ascii;

  modport master (
    output key_valid, key_code, key_break, key_ext, key_ascii,
    input  key_ready
  );

  modport slave (
    input  key_valid, key_code, key_break, key_ext, key_ascii,
    output key_ready
  );
endinterface

// File: rtl/ps2_frame_rx.sv
// PS/2 frame receiver: pad synchronisers, ps2_clk deglitch filter, 11-bit frame FSM, timeout.
module ps2_frame_rx import ps2_pkg::*; #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned FILTER_LEN  = 8,
  parameter int unsigned TIMEOUT_CYC = 100000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] rx_byte,
  output logic       byte_done,
  output logic       frame_err
);

  localparam int unsigned FW = $clog2(FILTER_LEN + 1);
  localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [FW-1:0] FltMax = FW'(FILTER_LEN - 1);
  localparam logic [TW-1:0] TmoMax = TW'(TIMEOUT_CYC);

  logic [SYNC_STAGES-1:0] clk_sync_q, data_sync_q;
  logic                   s_clk, s_data;
  logic                   filt_q;
  logic [FW-1:0]          flt_cnt_q;
  logic                   fall;

  rx_state_e              state_q;
  logic [2:0]             bit_cnt_q;
  logic [7:0]             shreg_q;
  logic                   par_q;
  logic [TW-1:0]          tmo_q;

  assign s_clk   = clk_sync_q[SYNC_STAGES-1];
  assign s_data  = data_sync_q[SYNC_STAGES-1];
  // Sampling edge is the cycle the filtered clock is about to drop.
  assign fall    = filt_q & ~s_clk & (flt_cnt_q == FltMax);
  assign rx_byte = shreg_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_sync_q  <= '0;
      data_sync_q <= '0;
      filt_q      <= 1'b0;
      flt_cnt_q   <= '0;
    end else begin
      clk_sync_q  <= {clk_sync_q[SYNC_STAGES-2:0], ps2_clk};
      data_sync_q <= {data_sync_q[SYNC_STAGES-2:0], ps2_data};
      if (s_clk != filt_q) begin
        if (flt_cnt_q == FltMax) begin
          filt_q    <= s_clk;
          flt_cnt_q <= '0;
        end else begin
          flt_cnt_q <= flt_cnt_q + 1'b1;
        end
      end else begin
        flt_cnt_q <= '0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      bit_cnt_q <= '0;
      shreg_q   <= '0;
      par_q     <= 1'b0;
      tmo_q     <= '0;
      byte_done <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      byte_done <= 1'b0;
      frame_err <= 1'b0;
      if (fall) begin
        tmo_q <= '0;
        unique case (state_q)
          StIdle: begin
            if (!s_data) begin
              state_q   <= StData;
              bit_cnt_q <= '0;
            end
          end
          StData: begin
            shreg_q   <= {s_data, shreg_q[7:1]};
            bit_cnt_q <= bit_cnt_q + 1'b1;
            if (bit_cnt_q == 3'd7) state_q <= StParity;
          end
          StParity: begin
            par_q   <= s_data;
            state_q <= StStop;
          end
          StStop: begin
            // Odd parity across data and parity bit, plus a high stop bit.
            if (s_data && (^{shreg_q, par_q})) byte_done <= 1'b1;
            else                               frame_err <= 1'b1;
            state_q <= StIdle;
          end
        endcase
      end else if (state_q == StIdle) begin
        tmo_q <= '0;
      end else if (tmo_q == TmoMax) begin
        frame_err <= 1'b1;
        state_q   <= StIdle;
        tmo_q     <= '0;
      end else begin
        tmo_q <= tmo_q + 1'b1;
      end
    end
  end

endmodule

// File: rtl/ps2_key_decoder.sv
// PS/2 keyboard decoder: E0/F0 prefix handling, event FIFO and ASCII map on the FIFO head.
module ps2_key_decoder import ps2_pkg::*; #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned FILTER_LEN  = 8,
  parameter int unsigned TIMEOUT_CYC = 100000,
  parameter int unsigned FIFO_DEPTH  = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ps2_clk,
  input  logic                ps2_data,
  ps2_key_decoder_if.master   key,
  output logic                frame_err,
  output logic                overflow
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FullCnt = (AW + 1)'(FIFO_DEPTH);

  logic [7:0]    rx_byte;
  logic          byte_done;

  logic          ext_q, brk_q;
  logic [9:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q;
  logic          overflow_q;

  logic          push, pop, full, do_push;
  logic [9:0]    head;

  ps2_frame_rx #(
    .SYNC_STAGES (SYNC_STAGES),
    .FILTER_LEN  (FILTER_LEN),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_rx (
    .clk       (clk),
    .rst       (rst),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .rx_byte   (rx_byte),
    .byte_done (byte_done),
    .frame_err (frame_err)
  );

  always_comb begin
    push    = byte_done && (rx_byte != PS2_PREFIX_EXT) && (rx_byte != PS2_PREFIX_BRK);
    full    = (count_q == FullCnt);
    pop     = key.key_valid && key.key_ready;
    // A pop in the same cycle frees the slot a full FIFO needs.
    do_push = push && (!full || pop);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ext_q      <= 1'b0;
      brk_q      <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      for (int i = 0; i < int'(FIFO_DEPTH); i++) mem_q[i] <= '0;
    end else begin
      overflow_q <= push && !do_push;
      if (byte_done) begin
        if (rx_byte == PS2_PREFIX_EXT) begin
          ext_q <= 1'b1;
        end else if (rx_byte == PS2_PREFIX_BRK) begin
          brk_q <= 1'b1;
        end else begin
          ext_q <= 1'b0;
          brk_q <= 1'b0;
        end
      end else if (frame_err) begin
        ext_q <= 1'b0;
        brk_q <= 1'b0;
      end
      if (do_push) begin
        mem_q[wr_ptr_q] <= {ext_q, brk_q, rx_byte};
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      unique case ({do_push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  assign head          = mem_q[rd_ptr_q];
  assign key.key_valid = (count_q != '0);
  assign key.key_code  = key.key_valid ? head[7:0] : 8'h00;
  assign key.key_break = key.key_valid & head[8];
  assign key.key_ext   = key.key_valid & head[9];
  assign key.key_ascii = key.key_valid ? ps2_to_ascii(head[9], head[7:0]) : ASCII_INVALID;
  assign overflow      = overflow_q;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Directed bench for ps2_key_decoder: PS/2 frames driven bit by bit, popped events checked in order.
module tb_ps2_key_decoder;

  localparam int unsigned TMO = 2000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ps2_clk = 1'b1;
  logic ps2_data = 1'b1;
  logic frame_err, overflow;

  ps2_key_decoder_if kif ();

  ps2_key_decoder #(
    .SYNC_STAGES (2),
    .FILTER_LEN  (8),
    .TIMEOUT_CYC (TMO),
    .FIFO_DEPTH  (8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .key       (kif),
    .frame_err (frame_err),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int err_cnt = 0;
  int ovf_cnt = 0;
  int valid_cyc = 0;
  // {ext, break, code, ascii} of every accepted event
  logic [17:0] ev_q[$];

  always @(negedge clk) begin
    if (!rst) begin
      if (frame_err) err_cnt++;
      if (overflow) ovf_cnt++;
      if (kif.key_valid) valid_cyc++;
      if (kif.key_valid && kif.key_ready)
        ev_q.push_back({kif.key_ext, kif.key_break, kif.key_code, kif.key_ascii});
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad_par, input int nbits);
    logic [10:0] f;
    f = {1'b1, (~^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      ps2_data = f[i];
      cyc(10);
      ps2_clk = 1'b0;
      cyc(20);
      ps2_clk = 1'b1;
      cyc(10);
    end
    ps2_data = 1'b1;
    cyc(20);
  endtask

  function automatic logic [17:0] take();
    if (ev_q.size() == 0) return 'x;
    return ev_q.pop_front();
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    kif.key_ready = 1'b0;
    cyc(4);
    if (kif.key_valid !== 1'b0) begin
      $display("FAIL reset_valid got=%b exp=0", kif.key_valid); bad++;
    end
    total++;
    rst = 1'b0;
    cyc(30);
    if ({kif.key_valid, kif.key_code, kif.key_break, kif.key_ext} !== 11'h000) begin
      $display("FAIL reset_head got=%b/%h/%b/%b exp=0/00/0/0", kif.key_valid, kif.key_code,
               kif.key_break, kif.key_ext); bad++;
    end
    total++;
    if (kif.key_ascii !== 8'hFE) begin
      $display("FAIL reset_ascii got=%h exp=fe", kif.key_ascii); bad++;
    end
    total++;
    if ({frame_err, overflow} !== 2'b00) begin
      $display("FAIL reset_pulses got=%b exp=00", {frame_err, overflow}); bad++;
    end
    total++;
  endtask

  task automatic test_make();
    int v0, n;
    logic [17:0] got;
    ev_q.delete();
    v0 = valid_cyc;
    kif.key_ready = 1'b1;
    send_frame(8'h16, 1'b0, 11);
    n = ev_q.size();
    got = take();
    if (n !== 1 || got !== {1'b0, 1'b0, 8'h16, 8'h31}) begin
      $display("FAIL make_16 got=n%0d %h exp=n1 %h", n, got, {1'b0, 1'b0, 8'h16, 8'h31}); bad++;
    end
    total++;
    if (valid_cyc - v0 !== 1) begin
      $display("FAIL make_pop_latency got=%0d exp=1 valid cycles", valid_cyc - v0); bad++;
    end
    total++;
  endtask

  task automatic test_break();
    int n;
    logic [17:0] got;
    ev_q.delete();
    send_frame(8'hF0, 1'b0, 11);
    send_frame(8'h16, 1'b0, 11);
    n = ev_q.size();
    got = take();
    if (n !== 1 || got !== {1'b0, 1'b1, 8'h16, 8'h31}) begin
      $display("FAIL break_16 got=n%0d %h exp=n1 %h", n, got, {1'b0, 1'b1, 8'h16, 8'h31}); bad++;
    end
    total++;
  endtask

  task automatic test_extended();
    int n;
    logic [17:0] got;
    ev_q.delete();
    send_frame(8'hE0, 1'b0, 11);
    send_frame(8'hF0, 1'b0, 11);
    send_frame(8'h5A, 1'b0, 11);
    send_frame(8'hE0, 1'b0, 11);
    send_frame(8'h75, 1'b0, 11);
    n = ev_q.size();
    if (n !== 2) begin
      $display("FAIL ext_count got=%0d exp=2", n); bad++;
    end
    total++;
    got = take();
    if (got !== {1'b1, 1'b1, 8'h5A, 8'h0A}) begin
      $display("FAIL ext_enter_brk got=%h exp=%h", got, {1'b1, 1'b1, 8'h5A, 8'h0A}); bad++;
    end
    total++;
    got = take();
    if (got !== {1'b1, 1'b0, 8'h75, 8'hFE}) begin
      $display("FAIL ext_75 got=%h exp=%h", got, {1'b1, 1'b0, 8'h75, 8'hFE}); bad++;
    end
    total++;
  endtask

  task automatic test_parity_err();
    int e0, n;
    logic [17:0] got;
    ev_q.delete();
    e0 = err_cnt;
    send_frame(8'h1E, 1'b1, 11);
    if (err_cnt - e0 !== 1 || ev_q.size() !== 0) begin
      $display("FAIL parity_err got=err%0d ev%0d exp=err1 ev0", err_cnt - e0, ev_q.size()); bad++;
    end
    total++;
    send_frame(8'h26, 1'b0, 11);
    n = ev_q.size();
    got = take();
    if (n !== 1 || got !== {1'b0, 1'b0, 8'h26, 8'h33}) begin
      $display("FAIL parity_recover got=n%0d %h exp=n1 %h", n, got, {1'b0, 1'b0, 8'h26, 8'h33});
      bad++;
    end
    total++;
    e0 = err_cnt;
    send_frame(8'hF0, 1'b0, 11);
    send_frame(8'h1E, 1'b1, 11);
    send_frame(8'h26, 1'b0, 11);
    n = ev_q.size();
    got = take();
    if (n !== 1 || got !== {1'b0, 1'b0, 8'h26, 8'h33} || err_cnt - e0 !== 1) begin
      $display("FAIL orphan_brk got=n%0d %h err%0d exp=n1 %h err1", n, got, err_cnt - e0,
               {1'b0, 1'b0, 8'h26, 8'h33}); bad++;
    end
    total++;
  endtask

  task automatic test_timeout();
    int e0, n;
    logic [17:0] got;
    ev_q.delete();
    e0 = err_cnt;
    send_frame(8'h00, 1'b0, 5);
    cyc(TMO + 10);
    if (err_cnt - e0 !== 1 || ev_q.size() !== 0) begin
      $display("FAIL timeout_err got=err%0d ev%0d exp=err1 ev0", err_cnt - e0, ev_q.size()); bad++;
    end
    total++;
    send_frame(8'h45, 1'b0, 11);
    n = ev_q.size();
    got = take();
    if (n !== 1 || got !== {1'b0, 1'b0, 8'h45, 8'h30} || err_cnt - e0 !== 1) begin
      $display("FAIL timeout_recover got=n%0d %h err%0d exp=n1 %h err1", n, got, err_cnt - e0,
               {1'b0, 1'b0, 8'h45, 8'h30}); bad++;
    end
    total++;
  endtask

  task automatic test_overflow();
    logic [7:0] codes [9];
    logic [7:0] ascii [9];
    int o0, e0, n;
    logic [17:0] got;
    codes = '{8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};
    ascii = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
    ev_q.delete();
    kif.key_ready = 1'b0;
    cyc(2);
    o0 = ovf_cnt;
    for (int i = 0; i < 8; i++) send_frame(codes[i], 1'b0, 11);
    if (ovf_cnt - o0 !== 0) begin
      $display("FAIL ovf_early got=%0d exp=0", ovf_cnt - o0); bad++;
    end
    total++;
    send_frame(codes[8], 1'b0, 11);
    if (ovf_cnt - o0 !== 1 || kif.key_valid !== 1'b1) begin
      $display("FAIL ovf_ninth got=ovf%0d valid%b exp=ovf1 valid1", ovf_cnt - o0, kif.key_valid);
      bad++;
    end
    total++;
    // 3-cycle low glitch with data low must not look like a start bit
    e0 = err_cnt;
    ps2_data = 1'b0;
    ps2_clk = 1'b0;
    cyc(3);
    ps2_clk = 1'b1;
    cyc(5);
    ps2_data = 1'b1;
    cyc(TMO + 100);
    if (err_cnt - e0 !== 0) begin
      $display("FAIL glitch got=err%0d exp=err0", err_cnt - e0); bad++;
    end
    total++;
    kif.key_ready = 1'b1;
    cyc(20);
    n = ev_q.size();
    if (n !== 8) begin
      $display("FAIL drain_count got=%0d exp=8", n); bad++;
    end
    total++;
    for (int i = 0; i < 8; i++) begin
      got = take();
      if (got !== {1'b0, 1'b0, codes[i], ascii[i]}) begin
        $display("FAIL drain_%0d got=%h exp=%h", i, got, {1'b0, 1'b0, codes[i], ascii[i]}); bad++;
      end
      total++;
    end
  endtask

  task automatic test_reset_mid_frame();
    int e0, n;
    logic [17:0] got;
    kif.key_ready = 1'b0;
    cyc(2);
    send_frame(8'h16, 1'b0, 11);
    send_frame(8'hF0, 1'b0, 11);
    send_frame(8'h00, 1'b0, 3);
    rst = 1'b1;
    cyc(3);
    if (kif.key_valid !== 1'b0) begin
      $display("FAIL midrst_flush got=%b exp=0", kif.key_valid); bad++;
    end
    total++;
    rst = 1'b0;
    cyc(30);
    ev_q.delete();
    e0 = err_cnt;
    kif.key_ready = 1'b1;
    send_frame(8'h1E, 1'b0, 11);
    n = ev_q.size();
    got = take();
    if (n !== 1 || got !== {1'b0, 1'b0, 8'h1E, 8'h32} || err_cnt - e0 !== 0) begin
      $display("FAIL midrst_clean got=n%0d %h err%0d exp=n1 %h err0", n, got, err_cnt - e0,
               {1'b0, 1'b0, 8'h1E, 8'h32}); bad++;
    end
    total++;
  endtask

  initial begin
    kif.key_ready = 1'b0;
    test_reset();
    test_make();
    test_break();
    test_extended();
    test_parity_err();
    test_timeout();
    test_overflow();
    test_reset_mid_frame();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
